// File: rtl/h264_pkg.sv
// rtl/h264_pkg.sv - shared macroblock constants and scan scheduler state type
//   MB_SIZE       : macroblock edge length in pixels
//   COORD_W       : width of every pixel coordinate
//   sched_state_t : scan scheduler FSM encoding
package h264_pkg;

  localparam int MB_SIZE = 16;
  localparam int COORD_W = 32;

  // Explicit codes keep the encoding stable for anything that decodes the state.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_KICK  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/mb_coord_counter.sv
// rtl/mb_coord_counter.sv - raster-order macroblock coordinate stepper
//   clk, rst        : clock, asynchronous active-high reset
//   advance         : step to the next macroblock in raster order
//   clear           : return to (0,0); wins over advance
//   mb_x, mb_y      : top-left pixel of the current macroblock
//   last_mb         : current macroblock is the bottom-right one of the frame
module mb_coord_counter
  import h264_pkg::*;
#(
  parameter int WIDTH  = 352,
  parameter int HEIGHT = 288
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               advance,
  input  logic               clear,
  output logic [COORD_W-1:0] mb_x,
  output logic [COORD_W-1:0] mb_y,
  output logic               last_mb
);

  localparam logic [COORD_W-1:0] STEP    = COORD_W'(MB_SIZE);
  localparam logic [COORD_W-1:0] FRAME_W = COORD_W'(WIDTH);
  localparam logic [COORD_W-1:0] LAST_X  = COORD_W'(WIDTH - MB_SIZE);
  localparam logic [COORD_W-1:0] LAST_Y  = COORD_W'(HEIGHT - MB_SIZE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mb_x <= '0;
      mb_y <= '0;
    end else if (clear) begin
      mb_x <= '0;
      mb_y <= '0;
    end else if (advance) begin
      if (mb_x + STEP < FRAME_W) begin
        mb_x <= mb_x + STEP;
      end else begin
        mb_x <= '0;
        mb_y <= mb_y + STEP;
      end
    end
  end

  assign last_mb = (mb_x == LAST_X) && (mb_y == LAST_Y);

endmodule

// File: rtl/mb_scan_scheduler.sv
// rtl/mb_scan_scheduler.sv - walks a frame macroblock by macroblock: fetch 16 rows, kick encoder, wait
//   clk, rst            : clock, asynchronous active-high reset
//   start               : frame start request (only honoured in IDLE)
//   fetch_req/fetch_ack : row request handshake to the pixel loader
//   fetch_x, fetch_y    : pixel position of the requested row segment
//   enc_start/enc_done  : encoder kick pulse and completion (done only honoured in WAIT)
//   mb_x, mb_y          : top-left pixel of the current macroblock
//   busy                : any state other than IDLE
//   frame_done          : one-cycle pulse after the last macroblock completes
module mb_scan_scheduler
  import h264_pkg::*;
#(
  parameter int WIDTH  = 352,
  parameter int HEIGHT = 288
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               fetch_req,
  input  logic               fetch_ack,
  output logic [COORD_W-1:0] fetch_x,
  output logic [COORD_W-1:0] fetch_y,
  output logic               enc_start,
  input  logic               enc_done,
  output logic [COORD_W-1:0] mb_x,
  output logic [COORD_W-1:0] mb_y,
  output logic               busy,
  output logic               frame_done
);

  sched_state_t state;
  logic [3:0]   row;
  logic         last_mb;
  logic         coord_clear;
  logic         coord_advance;

  assign coord_clear   = (state == ST_IDLE) && start;
  // The last macroblock keeps its coordinates so they remain visible after the frame.
  assign coord_advance = (state == ST_WAIT) && enc_done && !last_mb;

  mb_coord_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_coord (
    .clk     (clk),
    .rst     (rst),
    .advance (coord_advance),
    .clear   (coord_clear),
    .mb_x    (mb_x),
    .mb_y    (mb_y),
    .last_mb (last_mb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      row   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_FETCH;
            row   <= '0;
          end
        end
        ST_FETCH: begin
          // Row stays at 15 through KICK/WAIT; it only wraps when the next MB begins.
          if (fetch_ack) begin
            if (row == 4'd15) state <= ST_KICK;
            else              row   <= row + 4'd1;
          end
        end
        ST_KICK: state <= ST_WAIT;
        ST_WAIT: begin
          if (enc_done) begin
            if (last_mb) begin
              state <= ST_DONE;
            end else begin
              state <= ST_FETCH;
              row   <= '0;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request position derives only from registers, so it is stable while the loader stalls.
  assign fetch_req  = (state == ST_FETCH);
  assign fetch_x    = mb_x;
  assign fetch_y    = mb_y + COORD_W'(row);
  assign enc_start  = (state == ST_KICK);
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_mb_scan_scheduler.sv
// tb/tb_mb_scan_scheduler.sv - directed self-checking bench for mb_scan_scheduler (32x32, 16x16, 352x288)
module tb_mb_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        start_i[3];
  logic        fetch_ack_i[3];
  logic        enc_done_i[3];
  logic        fetch_req_w[3];
  logic        enc_start_w[3];
  logic        busy_w[3];
  logic        frame_done_w[3];
  logic [31:0] fetch_x_w[3];
  logic [31:0] fetch_y_w[3];
  logic [31:0] mb_x_w[3];
  logic [31:0] mb_y_w[3];

  int n_cmp = 0;
  int n_bad = 0;

  int          enc_cnt[3];
  int          ack_cnt[3];
  int          fd_cnt[3];
  int          seq_err[3];
  int          exp_row[3];
  logic [31:0] last_x[3];
  logic [31:0] last_y[3];
  int          seq_x[$];
  int          seq_y[$];

  always #5 clk = ~clk;

  mb_scan_scheduler #(.WIDTH(32), .HEIGHT(32)) dut0 (
    .clk(clk), .rst(rst), .start(start_i[0]),
    .fetch_req(fetch_req_w[0]), .fetch_ack(fetch_ack_i[0]),
    .fetch_x(fetch_x_w[0]), .fetch_y(fetch_y_w[0]),
    .enc_start(enc_start_w[0]), .enc_done(enc_done_i[0]),
    .mb_x(mb_x_w[0]), .mb_y(mb_y_w[0]),
    .busy(busy_w[0]), .frame_done(frame_done_w[0])
  );

  mb_scan_scheduler #(.WIDTH(16), .HEIGHT(16)) dut1 (
    .clk(clk), .rst(rst), .start(start_i[1]),
    .fetch_req(fetch_req_w[1]), .fetch_ack(fetch_ack_i[1]),
    .fetch_x(fetch_x_w[1]), .fetch_y(fetch_y_w[1]),
    .enc_start(enc_start_w[1]), .enc_done(enc_done_i[1]),
    .mb_x(mb_x_w[1]), .mb_y(mb_y_w[1]),
    .busy(busy_w[1]), .frame_done(frame_done_w[1])
  );

  mb_scan_scheduler dut2 (
    .clk(clk), .rst(rst), .start(start_i[2]),
    .fetch_req(fetch_req_w[2]), .fetch_ack(fetch_ack_i[2]),
    .fetch_x(fetch_x_w[2]), .fetch_y(fetch_y_w[2]),
    .enc_start(enc_start_w[2]), .enc_done(enc_done_i[2]),
    .mb_x(mb_x_w[2]), .mb_y(mb_y_w[2]),
    .busy(busy_w[2]), .frame_done(frame_done_w[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: counts pulses/accepted rows and checks every accepted row is the next one.
  always @(negedge clk) begin
    if (clr) begin
      for (int k = 0; k < 3; k++) begin
        enc_cnt[k] <= 0;
        ack_cnt[k] <= 0;
        fd_cnt[k]  <= 0;
        seq_err[k] <= 0;
        exp_row[k] <= 0;
      end
      seq_x.delete();
      seq_y.delete();
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (enc_start_w[k]) begin
          enc_cnt[k] <= enc_cnt[k] + 1;
          last_x[k]  <= mb_x_w[k];
          last_y[k]  <= mb_y_w[k];
          if (k == 0) begin
            seq_x.push_back(int'(mb_x_w[k]));
            seq_y.push_back(int'(mb_y_w[k]));
          end
        end
        if (fetch_req_w[k] && fetch_ack_i[k]) begin
          ack_cnt[k] <= ack_cnt[k] + 1;
          if (fetch_y_w[k] != mb_y_w[k] + 32'(exp_row[k])) seq_err[k] <= seq_err[k] + 1;
          exp_row[k] <= (exp_row[k] + 1) % 16;
        end
        if (frame_done_w[k]) fd_cnt[k] <= fd_cnt[k] + 1;
      end
    end
  end

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk);
    #1;
    clr = 1'b0;
  endtask

  // mode 0: plain frame; 1: ack withheld at row 5 of MB (0,0);
  // 2: start during WAIT and enc_done during FETCH; 3: reset during FETCH of MB (0,16)
  task automatic run_frame(input int k, input int mode, input int budget);
    int dly, c, hp, last_ed;
    bit done, stop, ed;
    dly = 0; hp = 0; last_ed = -10; done = 0; stop = 0; c = 0;
    fetch_ack_i[k] = 1'b1;
    enc_done_i[k]  = 1'b0;
    start_i[k]     = 1'b1;
    @(posedge clk); #1;
    start_i[k] = 1'b0;
    chk($sformatf("start_latency_%0d", k), 32'(fetch_req_w[k]), 1);
    while (!stop && c < budget) begin
      if (frame_done_w[k]) begin
        done = 1; stop = 1;
        chk($sformatf("fd_after_enc_done_%0d", k), 32'(c - last_ed), 1);
      end else begin
        ed = 0;
        if (dly > 0) begin
          dly--;
          if (dly == 0) begin ed = 1; last_ed = c; end
        end
        if (enc_start_w[k]) dly = 3;
        if (mode == 2 && fetch_req_w[k] && (fetch_y_w[k] - mb_y_w[k]) == 32'd3) ed = 1;
        enc_done_i[k] = ed;
        start_i[k] = (mode == 2) && busy_w[k] && !fetch_req_w[k] && !enc_start_w[k];
        fetch_ack_i[k] = 1'b1;
        if (mode == 1) begin
          if (hp == 0 && fetch_req_w[k] && mb_x_w[k] == 0 && mb_y_w[k] == 0 && fetch_y_w[k] == 5) hp = 1;
          if (hp >= 1 && hp <= 3) begin
            chk($sformatf("hold_req_%0d", hp), 32'(fetch_req_w[k]), 1);
            chk($sformatf("hold_y_%0d", hp), fetch_y_w[k], 5);
            fetch_ack_i[k] = (hp == 3);
            hp++;
          end
        end
        if (mode == 3 && fetch_req_w[k] && mb_x_w[k] == 0 && mb_y_w[k] == 16 && fetch_y_w[k] == 20) begin
          #2 rst = 1'b1;
          #1;
          chk("rst_fetch_req", 32'(fetch_req_w[k]), 0);
          chk("rst_busy", 32'(busy_w[k]), 0);
          chk("rst_mb_y", mb_y_w[k], 0);
          chk("rst_fetch_y", fetch_y_w[k], 0);
          chk("rst_frame_done", 32'(frame_done_w[k]), 0);
          @(posedge clk); #1;
          rst  = 1'b0;
          stop = 1;
        end
      end
      if (!stop) begin
        @(posedge clk); #1;
        c++;
      end
    end
    if (mode != 3 && !done) chk($sformatf("frame_timeout_%0d", k), 0, 1);
    start_i[k]    = 1'b0;
    enc_done_i[k] = 1'b0;
    if (done) begin
      @(posedge clk); #1;
      chk($sformatf("busy_after_%0d", k), 32'(busy_w[k]), 0);
      chk($sformatf("fd_one_cycle_%0d", k), 32'(frame_done_w[k]), 0);
    end
  endtask

  task automatic check_32x32(input string tag);
    int ex[4];
    int ey[4];
    ex = '{0, 16, 0, 16};
    ey = '{0, 0, 16, 16};
    @(negedge clk); #1;
    chk({tag, "_enc"}, enc_cnt[0], 4);
    chk({tag, "_acks"}, ack_cnt[0], 64);
    chk({tag, "_fd"}, fd_cnt[0], 1);
    chk({tag, "_rowseq"}, seq_err[0], 0);
    chk({tag, "_seqlen"}, seq_x.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_mbx%0d", tag, i), (i < seq_x.size()) ? seq_x[i] : -1, ex[i]);
      chk($sformatf("%s_mby%0d", tag, i), (i < seq_y.size()) ? seq_y[i] : -1, ey[i]);
    end
    chk({tag, "_final_x"}, mb_x_w[0], 16);
    chk({tag, "_final_y"}, mb_y_w[0], 16);
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_i[k] = 1'b0; fetch_ack_i[k] = 1'b0; enc_done_i[k] = 1'b0;
    end
    @(posedge clk); @(posedge clk); #1;
    chk("reset_busy", 32'(busy_w[0]), 0);
    chk("reset_fetch_req", 32'(fetch_req_w[0]), 0);
    chk("reset_enc_start", 32'(enc_start_w[0]), 0);
    chk("reset_frame_done", 32'(frame_done_w[0]), 0);
    chk("reset_mb_x", mb_x_w[0], 0);
    chk("reset_mb_y", mb_y_w[0], 0);
    chk("reset_fetch_x", fetch_x_w[0], 0);
    chk("reset_fetch_y", fetch_y_w[0], 0);
    rst = 1'b0;

    // No start: stays idle even with acks and enc_done wiggling.
    fetch_ack_i[0] = 1'b1; enc_done_i[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy_w[0]), 0);
    chk("idle_fetch_req", 32'(fetch_req_w[0]), 0);
    enc_done_i[0] = 1'b0;

    clear_mon();
    run_frame(0, 0, 500);
    check_32x32("basic");

    clear_mon();
    run_frame(0, 1, 500);
    check_32x32("stall");

    clear_mon();
    run_frame(0, 2, 500);
    check_32x32("ignore");

    clear_mon();
    run_frame(0, 3, 500);
    @(negedge clk); #1;
    chk("abort_no_fd", fd_cnt[0], 0);
    chk("abort_idle", 32'(busy_w[0]), 0);
    clear_mon();
    run_frame(0, 0, 500);
    check_32x32("restart");

    clear_mon();
    run_frame(1, 0, 200);
    @(negedge clk); #1;
    chk("single_enc", enc_cnt[1], 1);
    chk("single_acks", ack_cnt[1], 16);
    chk("single_fd", fd_cnt[1], 1);
    chk("single_rowseq", seq_err[1], 0);

    clear_mon();
    run_frame(2, 0, 12000);
    @(negedge clk); #1;
    chk("cif_enc", enc_cnt[2], 396);
    chk("cif_acks", ack_cnt[2], 6336);
    chk("cif_fd", fd_cnt[2], 1);
    chk("cif_rowseq", seq_err[2], 0);
    chk("cif_last_x", last_x[2], 336);
    chk("cif_last_y", last_y[2], 272);
    chk("cif_final_x", mb_x_w[2], 336);
    chk("cif_final_y", mb_y_w[2], 272);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mb_scan_scheduler.md
MB_SCAN_SCHEDULER -- requirements
Module: mb_scan_scheduler

Interface
REQ-001 Parameter WIDTH, default 352, frame width in pixels; SHALL be a nonzero multiple of 16.
REQ-002 Parameter HEIGHT, default 288, frame height in pixels; SHALL be a nonzero multiple of 16.
REQ-003 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  frame start request, sampled only in IDLE.
REQ-006 fetch_req  output  1  row-fetch request to pixel loader.
REQ-007 fetch_ack  input  1  loader accepts current row request.
REQ-008 fetch_x  output  32  pixel column of requested row segment (= mb_x).
REQ-009 fetch_y  output  32  pixel row of requested segment (= mb_y + row index).
REQ-010 enc_start  output  1  one-cycle pulse: MB fully loaded, core may encode.
REQ-011 enc_done  input  1  core finished current MB, sampled only in WAIT.
REQ-012 mb_x  output  32  pixel column of current MB top-left corner.
REQ-013 mb_y  output  32  pixel row of current MB top-left corner.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 frame_done  output  1  one-cycle pulse after last MB completes.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, KICK, WAIT, DONE.
REQ-017 IDLE: start=1 -> FETCH next cycle with mb_x=0, mb_y=0, row=0; else stay.
REQ-018 FETCH: fetch_req=1; fetch_x/fetch_y SHALL be held stable until fetch_ack=1.
REQ-019 FETCH: fetch_ack=1 in same cycle as fetch_req completes the row; row increments; ack on row 15 -> KICK.
REQ-020 Back-to-back acks SHALL fetch one row per cycle; 16 fetch cycles minimum per MB.
REQ-021 fetch_ack outside FETCH SHALL be ignored.
REQ-022 KICK: enc_start=1 exactly one cycle -> WAIT; fetch_req=0.
REQ-023 WAIT: enc_done=1 and not last MB -> advance coordinates, row=0, FETCH.
REQ-024 Advance: mb_x+16 < WIDTH -> mb_x+=16; else mb_x=0, mb_y+=16.
REQ-025 Last MB = (mb_x == WIDTH-16) and (mb_y == HEIGHT-16); enc_done there -> DONE, coordinates unchanged.
REQ-026 DONE: frame_done=1 one cycle -> IDLE; mb_x, mb_y hold last values.
REQ-027 enc_done outside WAIT SHALL be ignored; start outside IDLE SHALL be ignored, including simultaneous with enc_done.
REQ-028 Latency: start sampled in cycle N -> fetch_req=1 in cycle N+1.
REQ-029 Coordinate arithmetic 32-bit unsigned; row counter 4-bit, wraps 15->0 only on MB advance.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, row=0, mb_x=0, mb_y=0, all outputs 0, regardless of clk.
REQ-031 Reset mid-frame SHALL abandon the frame; next start restarts at (0,0), no frame_done issued.

Structure
REQ-032 Shared package h264_pkg SHALL hold MB_SIZE=16, COORD_W=32, and the scheduler state enum type.
REQ-033 Coordinate stepping (REQ-024, REQ-025) SHALL be one sub-module mb_coord_counter (inputs advance, clear; outputs mb_x, mb_y, last_mb).

Verification
REQ-034 WIDTH=32, HEIGHT=32, fetch_ack tied 1, enc_done 3 cycles after enc_start -> MBs (0,0),(16,0),(0,16),(16,16), 4 enc_start pulses, 64 acks, one frame_done, busy low afterwards.
REQ-035 fetch_ack withheld 2 cycles at row 5 of MB (0,0) -> fetch_req and fetch_y=5 stable for 3 cycles, no row skipped or repeated.
REQ-036 start pulsed during WAIT and enc_done pulsed during FETCH -> both ignored, MB sequence and counts identical to REQ-034.
REQ-037 rst asserted asynchronously during FETCH of MB (0,16) -> outputs 0 before next edge, no frame_done; next start restarts at (0,0).
REQ-038 WIDTH=16, HEIGHT=16 -> single MB: 16 fetches, one enc_start, frame_done one cycle after enc_done sampled.
REQ-039 Default 352x288 -> 396 enc_start pulses, final mb_x=336, mb_y=272, one frame_done.
